// File: rtl/pipe_pkg.sv
// Shared types and default payload widths for the pipeline stage registers.
// Each constant is the bundle width at one stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 180;
    localparam int EX_MEM_W = 251;
    localparam int MEM_WB_W = 104;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready/data channel between two pipeline stages.
// The master drives the bundle and the slave answers with ready.
interface pipe_stage_hs_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = EX_MEM_W
);
    logic             valid;
    logic             ready;
    logic [0:WIDTH-1] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable, synchronous clear and asynchronous reset.
// Clear wins over load so that a squash can never leave stale data behind.
module pipe_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [0:WIDTH-1] d,
    output logic [0:WIDTH-1] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with flush and a saturating stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int WIDTH        = EX_MEM_W,
    parameter bit CLR_ON_FLUSH = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_hs_if.slave     up,
    pipe_stage_hs_if.master    down,
    output logic [CNT_W-1:0]   stall_cnt
);

    pipe_state_t      state;
    pipe_state_t      state_n;
    logic             accept;
    logic             load_main;
    logic             clear;
    logic             in_ready;
    logic             out_valid;
    logic [0:WIDTH-1] main_d;
    logic [0:WIDTH-1] main_q;

    assign out_valid  = (state != EMPTY);
    assign accept     = up.valid && in_ready && !flush;
    assign clear      = flush && CLR_ON_FLUSH;
    assign up.ready   = in_ready;
    assign down.valid = out_valid;
    assign down.data  = main_q;

`ifdef PIPE_SKID_EN
    logic             in_ready_q;
    logic             load_skid;
    logic             main_from_skid;
    logic [0:WIDTH-1] skid_q;

    assign in_ready = in_ready_q;
    assign main_d   = main_from_skid ? skid_q : up.data;

    // Ready comes from a flop so the downstream ready never reaches upstream combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_n != TWO);
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid),
        .clear (clear),
        .d     (up.data),
        .q     (skid_q)
    );
`else
    assign in_ready = !out_valid || down.ready;
    assign main_d   = up.data;
`endif

    pipe_data_reg #(.WIDTH(WIDTH)) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load_main),
        .clear (clear),
        .d     (main_d),
        .q     (main_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept) begin
`ifdef PIPE_SKID_EN
                    if (down.ready) begin
                        load_main = 1'b1;
                    end else begin
                        state_n   = TWO;
                        load_skid = 1'b1;
                    end
`else
                    load_main = 1'b1;
`endif
                end else if (down.ready) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
`ifdef PIPE_SKID_EN
                if (down.ready) begin
                    state_n        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
`else
                state_n = EMPTY;
`endif
            end
            default: state_n = EMPTY;
        endcase
        // Flush squashes both the held entries and this cycle's incoming bundle.
        if (flush) begin
            state_n   = EMPTY;
            load_main = 1'b0;
`ifdef PIPE_SKID_EN
            load_skid = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !down.ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
